cq_viola_sysid_checker: RTL and testbench
=========================================

Name: cq_viola_sysid_checker

Overview:
- Avalon-MM read master sitting directly downstream of the system-ID slave; consumes its two 32-bit words.
  - Word 0 (address 0) is the system ID.
  - Word 1 (address 1) is the generation timestamp.
- Compares both words against build-time expected values and exposes pass/fail, the captured words and a timeout flag.
- Boot/health logic uses the result to gate system bring-up and report a bitstream/software mismatch.

Parameters:
- EXPECTED_ID, 32'd538249235, expected word at address 0.
- EXPECTED_TS, 32'd1439432259, expected word at address 1.
- READ_LATENCY, 0, cycles from accepted read (read=1, waitrequest=0) to readdata valid; legal range 0..7.
- TIMEOUT_CYCLES, 255, max cycles waiting on waitrequest per read before abort; legal range 1..65535.
- AUTO_START, 1, 1 = launch one check automatically in the first cycle after reset release.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to (re)run the check
- avm_address  out  1  word select to sysid slave
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  slave read data
- busy  out  1  check in progress
- done  out  1  sticky: check finished (pass, fail or timeout)
- pass  out  1  sticky: both words matched
- id_ok  out  1  word 0 matched EXPECTED_ID
- ts_ok  out  1  word 1 matched EXPECTED_TS
- timeout  out  1  sticky: a read was aborted
- captured_id  out  32  last word read from address 0
- captured_ts  out  32  last word read from address 1

Behaviour:
- Reset (asynchronous, reset_n=0) forces all outputs to 0 and the FSM to IDLE. This includes avm_read, avm_address, captured words and flags.
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN.
- IDLE:
  - Entry condition: start=1, or the first cycle after reset release when AUTO_START=1.
  - On entry to a run: clear done/pass/id_ok/ts_ok/timeout, set busy=1, go to RD_ID.
- RD_ID:
  - Drive avm_read=1 and avm_address=0, held stable while avm_waitrequest=1.
  - Read is accepted in the cycle where avm_read=1 and waitrequest=0. avm_read deasserts the next cycle.
  - On accept: if READ_LATENCY=0, capture readdata in the same cycle and go to RD_TS; otherwise go to LAT_ID.
- LAT_ID: count READ_LATENCY cycles after accept, capture avm_readdata into captured_id on the last one, go to RD_TS.
- RD_TS / LAT_TS: identical to RD_ID / LAT_ID with avm_address=1, capturing into captured_ts, then go to FIN.
- Read strobe is never asserted for two consecutive accepted cycles; there is a minimum one idle cycle between the two reads.
- Comparisons are registered:
  - id_ok is updated when captured_id is loaded.
  - ts_ok is updated when captured_ts is loaded.
- FIN (one cycle): pass <= id_ok & ts_ok; done <= 1; busy <= 0; go to IDLE.
- Minimum run length with READ_LATENCY=0 and no stalls is 5 cycles from start to done=1, in the sequence start, RD_ID, RD_TS (after gap), FIN.
- Timeout:
  - A 16-bit counter increments each cycle in RD_* while waitrequest=1 and resets on state entry.
  - When the counter reaches TIMEOUT_CYCLES: drop avm_read, set timeout=1, done=1, pass=0, busy=0, go to IDLE. The captured word of the aborted read is unchanged.
- start while busy=1: ignored, with no restart and no flag change.
- start in the same cycle as FIN: ignored. A new run needs start in IDLE.
- Mid-run reset: outputs clear immediately and avm_read drops asynchronously. AUTO_START applies again after release.
- done/pass/timeout stay sticky until the next run starts or reset.

Decomposition:
- Package cq_viola_sysid_pkg holds:
  - FSM state encoding (3-bit enum/localparams).
  - SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1.
  - Default expected-value constants.
- One natural sub-module, cq_viola_sysid_rdseq: the per-read sequencer (strobe hold, latency counter, timeout counter) with a capture-strobe output. The top instantiates it once and walks it through both addresses.

Test Plan:
- Zero-wait slave returning 538249235 / 1439432259, AUTO_START=1 → after release: done=1, pass=1, id_ok=ts_ok=1, captured words equal the inputs, done within 5 cycles.
- Slave returns 0xDEADBEEF at address 0 and the correct TS → id_ok=0, ts_ok=1, pass=0, done=1, timeout=0, captured_id=0xDEADBEEF.
- waitrequest high for 3 cycles on each read, READ_LATENCY=2 → address/read stable during stalls, capture occurs exactly 2 cycles after accept, pass=1.
- waitrequest stuck high, TIMEOUT_CYCLES=10 → avm_read drops after 10 stalled cycles, timeout=1, done=1, pass=0, busy=0; a subsequent start with a healthy slave gives pass=1, timeout=0.
- start pulsed mid-run, plus reset_n asserted during LAT_TS → the mid-run start has no effect; under reset all outputs are 0 immediately and a fresh automatic run completes after release.
- AUTO_START=0 → no bus activity until start; two back-to-back runs each re-clear the flags at start.

Source files
------------

// File: rtl/cq_viola_sysid_pkg.sv
// cq_viola_sysid_pkg: shared state encoding, sysid word addresses and default expected values
package cq_viola_sysid_pkg;
  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN} state_t;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam logic [31:0] DEF_EXPECTED_ID = 32'd538249235;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'd1439432259;
endpackage

// File: rtl/cq_viola_sysid_rdseq.sv
// cq_viola_sysid_rdseq: one Avalon-MM read with strobe hold, read latency and stall timeout
module cq_viola_sysid_rdseq #(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic launch,
  input  logic addr_sel,
  input  logic waitrequest,
  output logic avm_read,
  output logic avm_address,
  output logic accept,
  output logic capture,
  output logic abort
);
  localparam logic [2:0]  LAST = 3'(READ_LATENCY == 0 ? 0 : READ_LATENCY - 1);
  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);
  logic        lat_q;
  logic [2:0]  lcnt;
  logic [15:0] tcnt;
  always_comb begin
    accept  = avm_read & ~waitrequest;
    abort   = avm_read & waitrequest & (tcnt == TMAX);
    capture = (READ_LATENCY == 0) ? accept : (lat_q & (lcnt == LAST));
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      lat_q       <= 1'b0;
      lcnt        <= '0;
      tcnt        <= '0;
    end else if (launch) begin
      avm_read    <= 1'b1;
      avm_address <= addr_sel;
      tcnt        <= '0;
    end else if (avm_read) begin
      avm_read <= ~(accept | abort);
      lat_q    <= accept & (READ_LATENCY != 0);
      lcnt     <= '0;
      tcnt     <= tcnt + 16'(waitrequest);
    end else if (lat_q) begin
      lat_q <= ~capture;
      lcnt  <= lcnt + 3'd1;
    end
endmodule

// File: rtl/cq_viola_sysid_checker.sv
// cq_viola_sysid_checker: reads sysid words 0/1 over Avalon-MM and checks them against build-time values
module cq_viola_sysid_checker
  import cq_viola_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);
  state_t state;
  logic   auto_q, launch, accept, capture, abort;
  // the second read is launched from the first RD_TS cycle, which doubles as the bus gap
  always_comb launch = (state == IDLE & (start | auto_q)) | (state == RD_TS & ~avm_read);
  cq_viola_sysid_rdseq #(.READ_LATENCY(READ_LATENCY), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_seq (
    .clock       (clock),
    .reset_n     (reset_n),
    .launch      (launch),
    .addr_sel    (state == IDLE ? SYSID_ADDR_ID : SYSID_ADDR_TS),
    .waitrequest (avm_waitrequest),
    .avm_read    (avm_read),
    .avm_address (avm_address),
    .accept      (accept),
    .capture     (capture),
    .abort       (abort)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      auto_q      <= AUTO_START;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else begin
      auto_q <= 1'b0;
      case (state)
        IDLE: if (start | auto_q) begin
          busy    <= 1'b1;
          done    <= 1'b0;
          pass    <= 1'b0;
          id_ok   <= 1'b0;
          ts_ok   <= 1'b0;
          timeout <= 1'b0;
          state   <= RD_ID;
        end
        RD_ID, LAT_ID: if (capture) begin
          captured_id <= avm_readdata;
          id_ok       <= avm_readdata == EXPECTED_ID;
          state       <= RD_TS;
        end else if (accept) state <= LAT_ID;
        RD_TS, LAT_TS: if (capture) begin
          captured_ts <= avm_readdata;
          ts_ok       <= avm_readdata == EXPECTED_TS;
          state       <= FIN;
        end else if (accept) state <= LAT_TS;
        FIN: begin
          pass  <= id_ok & ts_ok;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (abort) begin
        timeout <= 1'b1;
        done    <= 1'b1;
        pass    <= 1'b0;
        busy    <= 1'b0;
        state   <= IDLE;
      end
    end
endmodule

// File: tb/tb_cq_viola_sysid_checker.sv
// tb_cq_viola_sysid_checker: directed checks on a zero-wait instance and a latency/timeout instance
module tb_cq_viola_sysid_checker;
  localparam logic [31:0] EID = 32'd538249235;
  localparam logic [31:0] ETS = 32'd1439432259;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, start0, start1, stuck1, stall3, rd1_any;
  logic [31:0] id0, ts0, id1, ts1, rdata0, rdata1;
  logic addr0, read0, busy0, done0, pass0, idok0, tsok0, tmo0;
  logic addr1, read1, busy1, done1, pass1, idok1, tsok1, tmo1, wr1;
  logic [31:0] cid0, cts0, cid1, cts1;
  logic p1v = 1'b0, p1a = 1'b0, p2v = 1'b0, p2a = 1'b0;
  logic [2:0] scnt = '0;
  int n_chk = 0, n_err = 0, c, n;

  assign rdata0 = read0 ? (addr0 ? ts0 : id0) : 32'h0;
  // slave for dut1: two-cycle read latency, optional 3-cycle stall or permanent stall
  assign wr1    = stuck1 | (stall3 & read1 & (scnt < 3'd3));
  assign rdata1 = p2v ? (p2a ? ts1 : id1) : 32'h0;
  always @(posedge clk) begin
    p1v  <= read1 & ~wr1;
    p1a  <= addr1;
    p2v  <= p1v;
    p2a  <= p1a;
    scnt <= (read1 & wr1) ? scnt + 3'd1 : (read1 ? scnt : 3'd0);
  end

  cq_viola_sysid_checker dut0 (
    .clock(clk), .reset_n(reset_n), .start(start0), .avm_address(addr0), .avm_read(read0),
    .avm_waitrequest(1'b0), .avm_readdata(rdata0), .busy(busy0), .done(done0), .pass(pass0),
    .id_ok(idok0), .ts_ok(tsok0), .timeout(tmo0), .captured_id(cid0), .captured_ts(cts0));
  cq_viola_sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(10), .AUTO_START(1'b0)) dut1 (
    .clock(clk), .reset_n(reset_n), .start(start1), .avm_address(addr1), .avm_read(read1),
    .avm_waitrequest(wr1), .avm_readdata(rdata1), .busy(busy1), .done(done1), .pass(pass1),
    .id_ok(idok1), .ts_ok(tsok1), .timeout(tmo1), .captured_id(cid1), .captured_ts(cts1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse(input bit which);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait0(output int cyc);
    cyc = 0;
    while (!done0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      rd1_any |= read1;
    end
    chk("wait0_bound", 32'(done0), 1);
  endtask

  task automatic wait1(output int cyc, output int nrd);
    logic pr, pw, pa;
    cyc = 0;
    nrd = int'(read1);
    pr = read1; pw = wr1; pa = addr1;
    while (!done1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (read1) nrd++;
      if (pr && pw && read1) chk("addr_hold", 32'(addr1), 32'(pa));
      pr = read1; pw = wr1; pa = addr1;
    end
    chk("wait1_bound", 32'(done1), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dut0"}, {24'b0, read0, addr0, busy0, done0, pass0, idok0, tsok0, tmo0}, 0);
    chk({tag, "_dut0_cap"}, cid0 | cts0, 0);
    chk({tag, "_dut1"}, {24'b0, read1, addr1, busy1, done1, pass1, idok1, tsok1, tmo1}, 0);
    chk({tag, "_dut1_cap"}, cid1 | cts1, 0);
  endtask

  initial begin
    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0; stuck1 = 1'b0; stall3 = 1'b0; rd1_any = 1'b0;
    id0 = EID; ts0 = ETS; id1 = EID; ts1 = ETS;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    // auto-start run on dut0, dut1 must stay silent
    reset_n = 1'b1;
    wait0(c);
    chk("auto_cycles", c, 5);
    chk("auto_pass", {pass0, idok0, tsok0, tmo0, busy0}, 5'b11100);
    chk("auto_cid", cid0, EID);
    chk("auto_cts", cts0, ETS);
    chk("dut1_idle", {rd1_any, busy1, done1}, 0);
    // wrong id word
    id0 = 32'hDEADBEEF;
    pulse(0);
    chk("clr_on_start", {done0, pass0, idok0, tsok0}, 0);
    wait0(c);
    chk("badid_cycles", c, 4);
    chk("badid_flags", {done0, pass0, idok0, tsok0, tmo0}, 5'b10010);
    chk("badid_cid", cid0, 32'hDEADBEEF);
    // start during FIN is ignored
    id0 = EID;
    pulse(0);
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("fin_done", {done0, pass0}, 2'b11);
    @(negedge clk);
    chk("fin_start_ignored", {busy0, read0}, 0);
    // stalled reads with latency 2
    stall3 = 1'b1;
    pulse(1);
    wait1(c, n);
    chk("stall_cycles", c, 14);
    chk("stall_reads", n, 8);
    chk("stall_flags", {done1, pass1, idok1, tsok1, tmo1, busy1}, 6'b111100);
    chk("stall_cid", cid1, EID);
    chk("stall_cts", cts1, ETS);
    // permanent stall: timeout after 10 cycles
    stall3 = 1'b0;
    stuck1 = 1'b1;
    pulse(1);
    wait1(c, n);
    chk("tmo_cycles", c, 10);
    chk("tmo_reads", n, 10);
    chk("tmo_flags", {tmo1, done1, pass1, busy1, read1}, 5'b11000);
    chk("tmo_cid_kept", cid1, EID);
    // recovery with healthy slave
    stuck1 = 1'b0;
    pulse(1);
    chk("tmo_clr", {tmo1, done1}, 0);
    wait1(c, n);
    chk("rec_cycles", c, 8);
    chk("rec_reads", n, 2);
    chk("rec_flags", {done1, pass1, tmo1}, 3'b110);
    // back-to-back run with wrong timestamp
    ts1 = 32'h12345678;
    pulse(1);
    chk("b2b_clr", {done1, pass1, idok1, tsok1}, 0);
    wait1(c, n);
    chk("b2b_cycles", c, 8);
    chk("b2b_flags", {done1, pass1, idok1, tsok1}, 4'b1010);
    chk("b2b_cts", cts1, 32'h12345678);
    // start pulsed mid-run has no effect
    ts1 = ETS;
    pulse(1);
    repeat (2) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait1(c, n);
    chk("midstart_cycles", c, 5);
    chk("midstart_flags", {done1, pass1, busy1}, 3'b110);
    // reset while dut1 sits in LAT_TS and dut0 is strobing its second read
    pulse(1);
    repeat (2) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_dut1", {busy1, read1}, 2'b10);
    chk("pre_rst_dut0", {read0, addr0}, 2'b11);
    reset_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rd1_any = 1'b0;
    reset_n = 1'b1;
    wait0(c);
    chk("rerun_cycles", c, 5);
    chk("rerun_flags", {done0, pass0, tmo0}, 3'b110);
    chk("rerun_dut1_idle", {rd1_any, busy1, done1}, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
